// File: rtl/id_ex_skid_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_skid_reg_if
// Purpose  : Handshake and field bundle between the decoder/register file
//            and the execute stage, passing through the ID/EX stage.
// Modports : slave  - the ID/EX stage (consumes in_*/*_i and out_ready,
//                     produces in_ready, out_valid and registered fields)
//            master - the surrounding environment (opposite directions)
// Revision : 1.0 - initial release
// ============================================================================
interface id_ex_skid_reg_if #(
  parameter int XLEN     = 32,
  parameter int RA_W     = 5,
  parameter int ALU_OP_W = 4
);
  // decode side
  logic                in_valid;
  logic                in_ready;
  logic [XLEN-1:0]     pc_i;
  logic [XLEN-1:0]     rs1_i;
  logic [XLEN-1:0]     rs2_i;
  logic [XLEN-1:0]     imm_i;
  logic [RA_W-1:0]     rd_i;
  logic [2:0]          funct3_i;
  logic [ALU_OP_W-1:0] alu_op_i;
  logic                alu_src_i;
  logic                pc_op_i;
  logic                mem_read_i;
  logic                mem_write_i;
  logic                mem_to_reg_i;
  logic                is_branch_i;
  // execute side
  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     pc;
  logic [XLEN-1:0]     op_a;
  logic [XLEN-1:0]     op_b;
  logic [XLEN-1:0]     store_data;
  logic [XLEN-1:0]     imm;
  logic [RA_W-1:0]     rd;
  logic [2:0]          funct3;
  logic [ALU_OP_W-1:0] alu_op;
  logic                mem_read;
  logic                mem_write;
  logic                mem_to_reg;
  logic                is_branch;

  modport slave (
    input  in_valid, pc_i, rs1_i, rs2_i, imm_i, rd_i, funct3_i, alu_op_i,
           alu_src_i, pc_op_i, mem_read_i, mem_write_i, mem_to_reg_i,
           is_branch_i, out_ready,
    output in_ready, out_valid, pc, op_a, op_b, store_data, imm, rd, funct3,
           alu_op, mem_read, mem_write, mem_to_reg, is_branch
  );

  modport master (
    output in_valid, pc_i, rs1_i, rs2_i, imm_i, rd_i, funct3_i, alu_op_i,
           alu_src_i, pc_op_i, mem_read_i, mem_write_i, mem_to_reg_i,
           is_branch_i, out_ready,
    input  in_ready, out_valid, pc, op_a, op_b, store_data, imm, rd, funct3,
           alu_op, mem_read, mem_write, mem_to_reg, is_branch
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_skid_reg
// Purpose  : ID/EX pipeline stage with valid/ready handshake and a 2-entry
//            (main + skid) buffer. ALU operands are selected at capture time.
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset
//            flush      - synchronous kill of all held entries
//            bus        - id_ex_skid_reg_if.slave (decode in, execute out)
//            stall_cnt  - cycles with out_valid && !out_ready   (optional)
//            bubble_cnt - cycles with !out_valid && !flush      (optional)
// Options  : ID_EX_PERF_EN - adds the saturating stall/bubble counters
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_skid_reg #(
  parameter int XLEN     = 32,
  parameter int RA_W     = 5,
  parameter int ALU_OP_W = 4,
  parameter int CNT_W    = 32
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             flush,
`ifdef ID_EX_PERF_EN
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      bubble_cnt,
`endif
  id_ex_skid_reg_if.slave       bus
);

  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     op_a;
    logic [XLEN-1:0]     op_b;
    logic [XLEN-1:0]     sd;
    logic [XLEN-1:0]     imm;
    logic [RA_W-1:0]     rd;
    logic [2:0]          f3;
    logic [ALU_OP_W-1:0] aop;
    logic                mr;
    logic                mw;
    logic                m2r;
    logic                br;
  } entry_t;

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  entry_t r_main;
  entry_t r_skid;
  logic   r_main_valid;
  logic   r_skid_valid;
  entry_t w_in;
  logic   w_accept;
  logic   w_drain;

  // Operands are resolved here so execute sees ready-to-use values.
  always_comb begin
    w_in      = '0;
    w_in.pc   = bus.pc_i;
    w_in.op_a = bus.pc_op_i   ? bus.pc_i  : bus.rs1_i;
    w_in.op_b = bus.alu_src_i ? bus.imm_i : bus.rs2_i;
    w_in.sd   = bus.rs2_i;
    w_in.imm  = bus.imm_i;
    w_in.rd   = bus.rd_i;
    w_in.f3   = bus.funct3_i;
    w_in.aop  = bus.alu_op_i;
    w_in.mr   = bus.mem_read_i;
    w_in.mw   = bus.mem_write_i;
    w_in.m2r  = bus.mem_to_reg_i;
    w_in.br   = bus.is_branch_i;
  end

  // in_ready depends only on skid occupancy, so no combinational path
  // exists from out_ready back to the decoder.
  assign w_accept = bus.in_valid && !r_skid_valid;
  assign w_drain  = r_main_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      // Only occupancy is killed; data keeps its last value.
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_main_valid || w_drain) begin
      // Skid is always older than the input, so it refills main first.
      // While skid is valid no accept can happen (in_ready is low).
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_main       <= w_in;
        r_main_valid <= 1'b1;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_accept) begin
      // Main is held by back-pressure; park the new entry in skid.
      r_skid       <= w_in;
      r_skid_valid <= 1'b1;
    end
  end

  assign bus.in_ready   = !r_skid_valid;
  assign bus.out_valid  = r_main_valid;
  assign bus.pc         = r_main.pc;
  assign bus.op_a       = r_main.op_a;
  assign bus.op_b       = r_main.op_b;
  assign bus.store_data = r_main.sd;
  assign bus.imm        = r_main.imm;
  assign bus.rd         = r_main.rd;
  assign bus.funct3     = r_main.f3;
  assign bus.alu_op     = r_main.aop;
  // Side-effect controls are qualified so a bubble can never act.
  assign bus.mem_read   = r_main.mr  && r_main_valid;
  assign bus.mem_write  = r_main.mw  && r_main_valid;
  assign bus.mem_to_reg = r_main.m2r && r_main_valid;
  assign bus.is_branch  = r_main.br  && r_main_valid;

`ifdef ID_EX_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (r_main_valid && !bus.out_ready && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (!r_main_valid && !flush && (r_bubble_cnt != '1)) begin
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_skid_reg
// Purpose  : Directed self-checking bench for id_ex_skid_reg: reset,
//            streaming, operand select, back-pressure, flush, mid-stream
//            reset and (with ID_EX_PERF_EN) the performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_skid_reg;
  localparam int XLEN     = 32;
  localparam int RA_W     = 5;
  localparam int ALU_OP_W = 4;
  localparam int CNT_W    = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   errors = 0;
  int   checks = 0;

  id_ex_skid_reg_if #(.XLEN(XLEN), .RA_W(RA_W), .ALU_OP_W(ALU_OP_W)) bus ();

`ifdef ID_EX_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;
`endif

  id_ex_skid_reg #(
    .XLEN(XLEN), .RA_W(RA_W), .ALU_OP_W(ALU_OP_W), .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
`ifdef ID_EX_PERF_EN
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt),
`endif
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm, input logic src,
                       input logic pcop, input logic mr, input logic mw);
    bus.in_valid     = v;
    bus.pc_i         = pc;
    bus.rs1_i        = rs1;
    bus.rs2_i        = rs2;
    bus.imm_i        = imm;
    bus.alu_src_i    = src;
    bus.pc_op_i      = pcop;
    bus.mem_read_i   = mr;
    bus.mem_write_i  = mw;
    bus.rd_i         = 5'd1;
    bus.funct3_i     = 3'd0;
    bus.alu_op_i     = 4'd0;
    bus.mem_to_reg_i = 1'b0;
    bus.is_branch_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    checks++; if ({bus.pc, bus.op_a, bus.op_b, bus.store_data, bus.imm} !== '0) begin errors++; $display("FAIL rst_data: got %h want 0", {bus.pc, bus.op_a, bus.op_b, bus.store_data, bus.imm}); end
    checks++; if ({bus.rd, bus.funct3, bus.alu_op, bus.mem_read, bus.mem_write, bus.mem_to_reg, bus.is_branch} !== '0) begin errors++; $display("FAIL rst_ctrl: got %h want 0", {bus.rd, bus.funct3, bus.alu_op}); end
    rst_n = 1'b1;
    step();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_idle_valid: got %b want 0", bus.out_valid); end
  endtask

`ifdef ID_EX_PERF_EN
  task automatic test_perf();
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    checks++; if ({stall_cnt, bubble_cnt} !== 8'h00) begin errors++; $display("FAIL perf_rst: got %h want 00", {stall_cnt, bubble_cnt}); end
    rst_n = 1'b1;
    drive(1, 32'h50, 0, 0, 0, 0, 0, 0, 0);
    step();                          // empty at this edge: bubble 1, A loads
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); step(); step();          // three stalled edges
    checks++; if (stall_cnt !== 4'd3) begin errors++; $display("FAIL perf_stall: got %0d want 3", stall_cnt); end
    checks++; if (bubble_cnt !== 4'd1) begin errors++; $display("FAIL perf_bubble_a: got %0d want 1", bubble_cnt); end
    bus.out_ready = 1'b1;
    step();                          // drain edge: neither counter moves
    step(); step();                  // two idle edges
    checks++; if (bubble_cnt !== 4'd3) begin errors++; $display("FAIL perf_bubble_b: got %0d want 3", bubble_cnt); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (bubble_cnt !== 4'd3) begin errors++; $display("FAIL perf_flush_bubble: got %0d want 3", bubble_cnt); end
    repeat (14) step();
    checks++; if (bubble_cnt !== 4'd15) begin errors++; $display("FAIL perf_saturate: got %0d want 15", bubble_cnt); end
    checks++; if (stall_cnt !== 4'd3) begin errors++; $display("FAIL perf_stall_hold: got %0d want 3", stall_cnt); end
  endtask
`endif

  task automatic test_stream();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'(i * 4), 32'hDEAD0000, 0, 0, 0, 1, 0, 0);
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, bus.in_ready); end
      step();
      checks++; if ({bus.out_valid, bus.pc, bus.op_a} !== {1'b1, 32'(i * 4), 32'(i * 4)}) begin errors++; $display("FAIL stream_out[%0d]: got v=%b pc=%h a=%h want v=1 pc=%h", i, bus.out_valid, bus.pc, bus.op_a, i * 4); end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_end: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_operand_mux();
    bus.out_ready = 1'b1;
    drive(1, 32'h100, 32'h11, 32'h22, 32'hFFFFFFF0, 1, 0, 1, 0);
    bus.rd_i = 5'd7; bus.funct3_i = 3'd5; bus.alu_op_i = 4'hA;
    step();
    checks++; if (bus.op_a !== 32'h11) begin errors++; $display("FAIL mux_op_a: got %h want 00000011", bus.op_a); end
    checks++; if (bus.op_b !== 32'hFFFFFFF0) begin errors++; $display("FAIL mux_op_b: got %h want fffffff0", bus.op_b); end
    checks++; if (bus.store_data !== 32'h22) begin errors++; $display("FAIL mux_store: got %h want 00000022", bus.store_data); end
    checks++; if ({bus.rd, bus.funct3, bus.alu_op, bus.mem_read} !== {5'd7, 3'd5, 4'hA, 1'b1}) begin errors++; $display("FAIL mux_fields: got rd=%0d f3=%0d op=%h mr=%b", bus.rd, bus.funct3, bus.alu_op, bus.mem_read); end
    drive(1, 32'h200, 32'h33, 32'h44, 32'h8, 0, 1, 1, 0);
    step();
    checks++; if ({bus.op_a, bus.op_b, bus.imm} !== {32'h200, 32'h44, 32'h8}) begin errors++; $display("FAIL mux_pc_rs2: got a=%h b=%h imm=%h want 200/44/8", bus.op_a, bus.op_b, bus.imm); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    checks++; if ({bus.out_valid, bus.mem_read, bus.pc} !== {1'b0, 1'b0, 32'h200}) begin errors++; $display("FAIL mux_bubble_gate: got v=%b mr=%b pc=%h want 0/0/200", bus.out_valid, bus.mem_read, bus.pc); end
  endtask

  task automatic test_back_pressure();
    bus.out_ready = 1'b0;
    drive(1, 32'h10, 0, 0, 0, 0, 1, 0, 0);
    step();
    checks++; if ({bus.out_valid, bus.pc, bus.in_ready} !== {1'b1, 32'h10, 1'b1}) begin errors++; $display("FAIL bp_a: got v=%b pc=%h rdy=%b want 1/10/1", bus.out_valid, bus.pc, bus.in_ready); end
    drive(1, 32'h14, 0, 0, 0, 0, 1, 0, 0);
    step();
    checks++; if ({bus.pc, bus.in_ready} !== {32'h10, 1'b0}) begin errors++; $display("FAIL bp_full: got pc=%h rdy=%b want 10/0", bus.pc, bus.in_ready); end
    drive(1, 32'h18, 0, 0, 0, 0, 1, 0, 1);
    step();
    checks++; if ({bus.pc, bus.op_a, bus.in_ready, bus.mem_write} !== {32'h10, 32'h10, 1'b0, 1'b0}) begin errors++; $display("FAIL bp_hold: got pc=%h a=%h rdy=%b mw=%b", bus.pc, bus.op_a, bus.in_ready, bus.mem_write); end
    bus.out_ready = 1'b1;
    step();
    checks++; if ({bus.out_valid, bus.pc, bus.in_ready} !== {1'b1, 32'h14, 1'b1}) begin errors++; $display("FAIL bp_drain_b: got v=%b pc=%h rdy=%b want 1/14/1", bus.out_valid, bus.pc, bus.in_ready); end
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if ({bus.out_valid, bus.pc, bus.mem_write} !== {1'b1, 32'h18, 1'b1}) begin errors++; $display("FAIL bp_drain_c: got v=%b pc=%h mw=%b want 1/18/1", bus.out_valid, bus.pc, bus.mem_write); end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive(1, 32'h40, 0, 0, 0, 0, 1, 0, 1);
    step();
    drive(1, 32'h44, 0, 0, 0, 0, 1, 0, 1);
    step();
    checks++; if ({bus.in_ready, bus.mem_write, bus.out_valid} !== 3'b011) begin errors++; $display("FAIL flush_pre: got rdy=%b mw=%b v=%b want 0/1/1", bus.in_ready, bus.mem_write, bus.out_valid); end
    flush = 1'b1;
    drive(1, 32'h48, 0, 0, 0, 0, 1, 0, 1);
    step();
    flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if ({bus.out_valid, bus.mem_write, bus.in_ready} !== 3'b001) begin errors++; $display("FAIL flush_kill: got v=%b mw=%b rdy=%b want 0/0/1", bus.out_valid, bus.mem_write, bus.in_ready); end
    checks++; if (bus.pc !== 32'h40) begin errors++; $display("FAIL flush_data_kept: got %h want 00000040", bus.pc); end
    bus.out_ready = 1'b1;
    flush = 1'b1;
    drive(1, 32'h4C, 0, 0, 0, 0, 1, 0, 1);
    step();
    flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if ({bus.out_valid, bus.pc} !== {1'b0, 32'h40}) begin errors++; $display("FAIL flush_discard: got v=%b pc=%h want 0/40", bus.out_valid, bus.pc); end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_emit: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b0;
    drive(1, 32'h80, 32'h5, 0, 0, 0, 1, 1, 1);
    step();
    drive(1, 32'h84, 32'h5, 0, 0, 0, 1, 1, 1);
    step();
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.out_valid, bus.in_ready, bus.mem_read, bus.mem_write} !== 4'b0100) begin errors++; $display("FAIL mrst_state: got v=%b rdy=%b mr=%b mw=%b want 0/1/0/0", bus.out_valid, bus.in_ready, bus.mem_read, bus.mem_write); end
    checks++; if ({bus.pc, bus.op_a} !== 64'h0) begin errors++; $display("FAIL mrst_data: got pc=%h a=%h want 0", bus.pc, bus.op_a); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b1;
    step();
    checks++; if ({bus.in_ready, bus.out_valid} !== 2'b10) begin errors++; $display("FAIL mrst_release: got rdy=%b v=%b want 1/0", bus.in_ready, bus.out_valid); end
  endtask

  initial begin
    test_reset();
`ifdef ID_EX_PERF_EN
    test_perf();
`endif
    test_stream();
    test_operand_mux();
    test_back_pressure();
    test_flush();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
